// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC bus readers: the bus FSM state encoding, the
// RTC register map, and the BCD validity / BCD-to-binary helpers.
// The BCD helpers take the 7 data bits that hold BCD; bit 7 of an RTC register
// is a flag bit, so the caller drops it before calling.
// -----------------------------------------------------------------------------
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_TURN  = 3'd2,
    ST_READ  = 3'd3,
    ST_CHECK = 3'd4
  } rtc_state_e;

  // RTC register map
  localparam logic [7:0] RTC_MIN_ADDR = 8'h22;

  // tens digit 0..5 and units digit 0..9
  function automatic logic bcd_valid(input logic [6:0] d);
    return (d[6:4] <= 3'd5) && (d[3:0] <= 4'd9);
  endfunction

  // tens*10 + units in 7 bits, truncated to 6 (<= 59 for valid input)
  function automatic logic [5:0] bcd_to_bin6(input logic [6:0] d);
    logic [6:0] sum;
    sum = ({4'b0000, d[6:4]} * 7'd10) + {3'b000, d[3:0]};
    return sum[5:0];
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
// Combinational RTC BCD register decoder, shared by the minute and hour readers.
// Ports:
//   i_bcd   [7:0] raw register byte (bit 7 is ignored)
//   o_bin   [5:0] binary value, meaningful only when o_valid = 1
//   o_valid       1 = both BCD digits in range
// -----------------------------------------------------------------------------
module bcd_to_bin
  import rtc_pkg::*;
(
  input  logic [7:0] i_bcd,
  output logic [5:0] o_bin,
  output logic       o_valid
);

  // bit 7 is an RTC flag bit, not part of the BCD value
  logic w_unused_flag;
  assign w_unused_flag = i_bcd[7];

  assign o_valid = bcd_valid(i_bcd[6:0]);
  assign o_bin   = bcd_to_bin6(i_bcd[6:0]);

endmodule

// File: rtl/rtc_min_reader.sv
// -----------------------------------------------------------------------------
// rtc_min_reader
// Polls the RTC minutes register over the multiplexed address/data bus and
// publishes the live minute value in binary.
// Transaction: ADDR (T_PHASE) -> TURN (T_PHASE) -> READ (T_PHASE) -> CHECK (1).
// Requests come from i_start or from the free-running poll timer; requests that
// arrive while a transaction is in progress are dropped.
// Optional build macro MIN_DOUBLE_READ_EN: each request reads the register twice
// back to back and accepts the value only if both samples agree (guards against
// the RTC rolling over mid-read); disagreeing pairs are retried, up to 4 pairs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         one-cycle request for an immediate read
//   i_ad_in   [7:0] bus data from RTC
//   o_ad_out  [7:0] bus value driven to RTC, o_ad_oe = drive enable
//   o_cs_n, o_rd_n, o_wr_n, o_ad_n   active-low RTC strobes (o_ad_n=0: address)
//   o_min_bin [5:0] last valid minute, o_min_valid pulses when it updates
//   o_busy          transaction in progress
//   o_bcd_err       sticky error, cleared by the next good read
// -----------------------------------------------------------------------------
module rtc_min_reader
  import rtc_pkg::*;
#(
  parameter logic [7:0] MIN_ADDR = RTC_MIN_ADDR,
  parameter int         T_PHASE  = 4,
  parameter int         POLL_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_ad_in,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic       o_ad_n,
  output logic [5:0] o_min_bin,
  output logic       o_min_valid,
  output logic       o_busy,
  output logic       o_bcd_err
);

  localparam int             PW         = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(T_PHASE - 1);
  localparam int             TW         = $clog2(POLL_DIV);
  localparam logic [TW-1:0]  POLL_LAST  = TW'(POLL_DIV - 1);

  rtc_state_e    r_state;
  rtc_state_e    w_next_state;
  logic [PW-1:0] r_phase;
  logic [TW-1:0] r_poll_cnt;
  logic          w_phase_end;
  logic          w_poll_tc;
  logic          w_req;
  logic          w_read_done;
  logic          w_to_addr;
  logic          w_more_xfer;
  logic          w_retry;

  logic [5:0]    w_bcd_bin;
  logic          w_bcd_valid;

  logic [7:0]    r_ad_out;
  logic          r_ad_oe, r_cs_n, r_rd_n, r_wr_n, r_ad_n, r_busy;
  logic [7:0]    w_ad_out_d;
  logic          w_ad_oe_d, w_cs_n_d, w_rd_n_d, w_wr_n_d, w_ad_n_d;
  logic [5:0]    r_min_bin;
  logic          r_min_valid;
  logic          r_bcd_err;

  assign w_phase_end = (r_phase == PHASE_LAST);
  assign w_poll_tc   = (r_poll_cnt == POLL_LAST);
  assign w_req       = i_start | w_poll_tc;
  assign w_read_done = (r_state == ST_READ) && w_phase_end;

  // Decode straight off the bus so the result is ready on the edge that
  // closes READ and is visible during CHECK.
  bcd_to_bin u_bcd (
    .i_bcd   (i_ad_in),
    .o_bin   (w_bcd_bin),
    .o_valid (w_bcd_valid)
  );

  // Poll timer: free-runs 0..POLL_DIV-1, never paused by a transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_poll_cnt <= {TW{1'b0}};
    end else if (w_poll_tc) begin
      r_poll_cnt <= {TW{1'b0}};
    end else begin
      r_poll_cnt <= r_poll_cnt + TW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Phase length counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= {PW{1'b0}};
    end else if (w_next_state != r_state) begin
      r_phase <= {PW{1'b0}};
    end else if (!w_phase_end) begin
      r_phase <= r_phase + PW'(1);
    end else begin
      r_phase <= r_phase;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) w_next_state = ST_ADDR;
        else       w_next_state = ST_IDLE;
      end
      ST_ADDR: begin
        if (w_phase_end) w_next_state = ST_TURN;
        else             w_next_state = ST_ADDR;
      end
      ST_TURN: begin
        if (!w_phase_end)   w_next_state = ST_TURN;
        else if (w_to_addr) w_next_state = ST_ADDR;
        else                w_next_state = ST_READ;
      end
      ST_READ: begin
        if (!w_phase_end)     w_next_state = ST_READ;
        else if (w_more_xfer) w_next_state = ST_TURN;
        else                  w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_retry) w_next_state = ST_ADDR;
        else         w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM output decode, from the next state so the registered bus pins line
  // up with the state register
  always_comb begin
    w_cs_n_d   = 1'b1;
    w_rd_n_d   = 1'b1;
    w_wr_n_d   = 1'b1;
    w_ad_n_d   = 1'b1;
    w_ad_oe_d  = 1'b0;
    w_ad_out_d = r_ad_out;
    case (w_next_state)
      ST_ADDR: begin
        w_cs_n_d   = 1'b0;
        w_ad_n_d   = 1'b0;
        w_wr_n_d   = 1'b0;
        w_ad_oe_d  = 1'b1;
        w_ad_out_d = MIN_ADDR;
      end
      ST_READ: begin
        w_cs_n_d = 1'b0;
        w_rd_n_d = 1'b0;
      end
      ST_IDLE, ST_TURN, ST_CHECK: begin
        w_cs_n_d  = 1'b1;
        w_ad_oe_d = 1'b0;
      end
      default: begin
        w_cs_n_d  = 1'b1;
        w_ad_oe_d = 1'b0;
      end
    endcase
  end

  // Registered bus pins and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
      r_busy   <= 1'b0;
    end else begin
      r_cs_n   <= w_cs_n_d;
      r_rd_n   <= w_rd_n_d;
      r_wr_n   <= w_wr_n_d;
      r_ad_n   <= w_ad_n_d;
      r_ad_oe  <= w_ad_oe_d;
      r_ad_out <= w_ad_out_d;
      r_busy   <= (w_next_state != ST_IDLE);
    end
  end

`ifdef MIN_DOUBLE_READ_EN
  logic       r_pass;     // 1 while the second read of a pair is in flight
  logic       r_between;  // TURN between the two reads, goes back to ADDR
  logic       r_retry;
  logic [1:0] r_pairs;
  logic [7:0] r_sample;

  assign w_to_addr   = r_between;
  assign w_more_xfer = ~r_pass;
  assign w_retry     = r_retry;

  // Tracks which read of the pair is running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass    <= 1'b0;
      r_between <= 1'b0;
    end else if (w_read_done) begin
      r_pass    <= ~r_pass;
      r_between <= ~r_pass;
    end else if ((r_state == ST_TURN) && w_phase_end) begin
      r_pass    <= r_pass;
      r_between <= 1'b0;
    end else begin
      r_pass    <= r_pass;
      r_between <= r_between;
    end
  end

  // Sample capture, pair compare/retry and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_bin   <= 6'd0;
      r_min_valid <= 1'b0;
      r_bcd_err   <= 1'b0;
      r_sample    <= 8'h00;
      r_retry     <= 1'b0;
      r_pairs     <= 2'd0;
    end else begin
      r_min_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_pairs <= 2'd0;
        r_retry <= 1'b0;
      end
      if (w_read_done && !r_pass) begin
        r_sample <= i_ad_in;
      end else if (w_read_done) begin
        if (i_ad_in == r_sample) begin
          r_retry <= 1'b0;
          if (w_bcd_valid) begin
            r_min_bin   <= w_bcd_bin;
            r_min_valid <= 1'b1;
            r_bcd_err   <= 1'b0;
          end else begin
            r_bcd_err <= 1'b1;
          end
        end else if (r_pairs == 2'd3) begin
          // fourth disagreeing pair: give up and hold the last good value
          r_retry   <= 1'b0;
          r_bcd_err <= 1'b1;
        end else begin
          r_retry <= 1'b1;
          r_pairs <= r_pairs + 2'd1;
        end
      end
    end
  end
`else
  assign w_to_addr   = 1'b0;
  assign w_more_xfer = 1'b0;
  assign w_retry     = 1'b0;

  // Result publication on the edge that closes READ
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_bin   <= 6'd0;
      r_min_valid <= 1'b0;
      r_bcd_err   <= 1'b0;
    end else begin
      r_min_valid <= 1'b0;
      if (w_read_done) begin
        if (w_bcd_valid) begin
          r_min_bin   <= w_bcd_bin;
          r_min_valid <= 1'b1;
          r_bcd_err   <= 1'b0;
        end else begin
          r_bcd_err <= 1'b1;
        end
      end
    end
  end
`endif

  assign o_ad_out    = r_ad_out;
  assign o_ad_oe     = r_ad_oe;
  assign o_cs_n      = r_cs_n;
  assign o_rd_n      = r_rd_n;
  assign o_wr_n      = r_wr_n;
  assign o_ad_n      = r_ad_n;
  assign o_busy      = r_busy;
  assign o_min_bin   = r_min_bin;
  assign o_min_valid = r_min_valid;
  assign o_bcd_err   = r_bcd_err;

endmodule

// File: tb/tb_rtc_min_reader.sv
// -----------------------------------------------------------------------------
// tb_rtc_min_reader
// Directed bench for rtc_min_reader (T_PHASE=4). The main instance has a long
// poll period and is driven by start; a second instance with POLL_DIV=50 is
// used for the poll-timer behaviour. Expected results are queued when a read
// is launched and popped in the CHECK cycle.
// -----------------------------------------------------------------------------
module tb_rtc_min_reader;

  localparam int T = 4;
`ifdef MIN_DOUBLE_READ_EN
  localparam int W = 7*T + 1;
`else
  localparam int W = 3*T + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic       i_start_p;
  logic [7:0] ad_in;

  logic [7:0] ad_out,  p_ad_out;
  logic       ad_oe,   p_ad_oe;
  logic       cs_n,    p_cs_n;
  logic       rd_n,    p_rd_n;
  logic       wr_n,    p_wr_n;
  logic       ad_n,    p_ad_n;
  logic [5:0] min_bin, p_min_bin;
  logic       min_valid, p_min_valid;
  logic       busy,    p_busy;
  logic       bcd_err, p_bcd_err;

  typedef struct {
    logic [5:0] bin;
    logic       err;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  int         rise_q[$];
  logic [7:0] s1[4];
  logic [7:0] s2[4];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  rtc_min_reader #(.MIN_ADDR(8'h22), .T_PHASE(T), .POLL_DIV(1000)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_ad_in(ad_in),
    .o_ad_out(ad_out), .o_ad_oe(ad_oe), .o_cs_n(cs_n), .o_rd_n(rd_n),
    .o_wr_n(wr_n), .o_ad_n(ad_n), .o_min_bin(min_bin),
    .o_min_valid(min_valid), .o_busy(busy), .o_bcd_err(bcd_err)
  );

  rtc_min_reader #(.MIN_ADDR(8'h22), .T_PHASE(T), .POLL_DIV(50)) u_poll (
    .clk(clk), .rst(rst), .i_start(i_start_p), .i_ad_in(ad_in),
    .o_ad_out(p_ad_out), .o_ad_oe(p_ad_oe), .o_cs_n(p_cs_n), .o_rd_n(p_rd_n),
    .o_wr_n(p_wr_n), .o_ad_n(p_ad_n), .o_min_bin(p_min_bin),
    .o_min_valid(p_min_valid), .o_busy(p_busy), .o_bcd_err(p_bcd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected {cs_n, rd_n, wr_n, ad_n, ad_oe, busy} at cycle 'off' of a window
  function automatic logic [5:0] ph_bits(input int off);
    int ph;
    if      (off <= T)   ph = 0;
    else if (off <= 2*T) ph = 1;
    else if (off <= 3*T) ph = 2;
`ifdef MIN_DOUBLE_READ_EN
    else if (off <= 4*T) ph = 1;
    else if (off <= 5*T) ph = 0;
    else if (off <= 6*T) ph = 1;
    else if (off <= 7*T) ph = 2;
`endif
    else                 ph = 3;
    case (ph)
      0:       return 6'b010011;  // ADDR
      1:       return 6'b111101;  // TURN
      2:       return 6'b001101;  // READ
      default: return 6'b111101;  // CHECK
    endcase
  endfunction

  // One request of 'pairs' windows; s1/s2 give the bus value for each window
  task automatic xact(input int pairs, input logic [5:0] eb, input logic eerr, input logic ev);
    exp_t e;
    int   n;
    n = pairs * W;
    sb.push_back('{bin: eb, err: eerr, v: ev});
    ad_in   = s1[0];
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int cyc = 1; cyc <= n; cyc++) begin
      int off;
      int p;
      logic [5:0] eph;
      if (cyc > 1) tick();
      off   = (cyc - 1) % W + 1;
      p     = (cyc - 1) / W;
      ad_in = (off <= 3*T) ? s1[p[1:0]] : s2[p[1:0]];
      eph   = ph_bits(off);
      chk("strobes", 32'({cs_n, rd_n, wr_n, ad_n, ad_oe, busy}), 32'(eph));
      if (eph == 6'b010011) chk("ad_out", 32'(ad_out), 32'(8'h22));
      chk("min_valid", 32'(min_valid), 32'((cyc == n) && ev));
      if (cyc == n) begin
        e = sb.pop_front();
        chk("min_bin", 32'(min_bin), 32'(e.bin));
        chk("bcd_err", 32'(bcd_err), 32'(e.err));
      end
    end
    tick();
    chk("idle_after", 32'({cs_n, rd_n, wr_n, ad_n, ad_oe, busy}), 32'(6'b111100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rise;
    int n_busy;
    logic prev;

    rst = 1'b1; i_start = 1'b0; i_start_p = 1'b0; ad_in = 8'h00;
    repeat (3) tick();
    chk("rst_strobes", 32'({cs_n, rd_n, wr_n, ad_n, ad_oe, busy}), 32'(6'b111100));
    chk("rst_ad_out", 32'(ad_out), 32'(8'h00));
    chk("rst_min", 32'({min_bin, min_valid, bcd_err}), 32'(8'h00));
    rst = 1'b0;
    tick();

    s1[0] = 8'h47; s2[0] = 8'h47; xact(1, 6'd47, 1'b0, 1'b1);
    s1[0] = 8'h6A; s2[0] = 8'h6A; xact(1, 6'd47, 1'b1, 1'b0);
    s1[0] = 8'h05; s2[0] = 8'h05; xact(1, 6'd5,  1'b0, 1'b1);
    s1[0] = 8'hD9; s2[0] = 8'hD9; xact(1, 6'd59, 1'b0, 1'b1);
`ifdef MIN_DOUBLE_READ_EN
    s1[0] = 8'h29; s2[0] = 8'h30; s1[1] = 8'h30; s2[1] = 8'h30;
    xact(2, 6'd30, 1'b0, 1'b1);
    s1[0] = 8'h10; s2[0] = 8'h11; s1[1] = 8'h11; s2[1] = 8'h12;
    s1[2] = 8'h12; s2[2] = 8'h13; s1[3] = 8'h13; s2[3] = 8'h14;
    xact(4, 6'd30, 1'b1, 1'b0);
`endif

    // reset in the middle of READ
    ad_in = 8'h12; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_read", 32'({cs_n, rd_n, busy}), 32'(3'b001));
    rst = 1'b1;
    tick();
    chk("mid_rst_strobes", 32'({cs_n, rd_n, wr_n, ad_n, ad_oe, busy}), 32'(6'b111100));
    chk("mid_rst_min_bin", 32'(min_bin), 32'(6'd0));
    chk("mid_rst_flags", 32'({min_valid, bcd_err}), 32'(2'b00));
    rst = 1'b0;

    // poll timer: requests at 50,100,150; start coincident with the first
    // terminal count and start while busy must not add transactions
    ad_in = 8'h33;
    rise_q.push_back(50); rise_q.push_back(100); rise_q.push_back(150);
    n_rise = 0; n_busy = 0; prev = 1'b0;
    for (int cyc = 1; cyc <= 180; cyc++) begin
      tick();
      i_start_p = (cyc == 49) || (cyc == 105);
      if (p_busy) n_busy++;
      if (p_busy && !prev) begin
        n_rise++;
        if (rise_q.size() > 0) chk("poll_rise", 32'(cyc), 32'(rise_q.pop_front()));
        else                   chk("poll_extra", 32'(cyc), 32'(0));
      end
      prev = p_busy;
    end
    chk("poll_count", 32'(n_rise), 32'(3));
    chk("poll_busy_cycles", 32'(n_busy), 32'(3 * W));
    chk("poll_min_bin", 32'(p_min_bin), 32'(6'd33));
    chk("poll_bcd_err", 32'(p_bcd_err), 32'(1'b0));
    chk("main_stays_idle", 32'(busy), 32'(1'b0));
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
